// File: rtl/ascon_job_scheduler_if.sv
// Host, core-array and result-FIFO signals of the ASCON job scheduler.
// Latency: none (wires only).
// Backpressure: carries valid/ready, request/grant and FIFO empty/read handshakes.
interface ascon_job_scheduler_if #(
    parameter int NUM_CORES = 2,
    parameter int RW        = 43
);
    logic                    job_req_i;
    logic                    job_gnt_o;
    logic [1:0]              job_core_o;
    logic                    in_valid_i;
    logic                    in_last_i;
    logic                    in_ready_o;
    logic [NUM_CORES-1:0]    core_valid_o;
    logic [NUM_CORES-1:0]    core_ready_i;
    logic [NUM_CORES-1:0]    core_idle_i;
    logic [NUM_CORES-1:0]    core_start_o;
    logic [NUM_CORES-1:0]    res_empty_i;
    logic [NUM_CORES-1:0]    res_rd_o;
    logic [NUM_CORES*RW-1:0] res_data_i;
    logic                    out_valid_o;
    logic [RW-1:0]           out_data_o;
    logic                    out_ready_i;
    logic                    job_done_o;
    logic [NUM_CORES-1:0]    busy_o;
    logic                    err_timeout_o;

    // Scheduler side.
    modport slave (
        input  job_req_i, in_valid_i, in_last_i, core_ready_i, core_idle_i,
               res_empty_i, res_data_i, out_ready_i,
        output job_gnt_o, job_core_o, in_ready_o, core_valid_o, core_start_o,
               res_rd_o, out_valid_o, out_data_o, job_done_o, busy_o, err_timeout_o
    );

    // Host / core-array side.
    modport master (
        output job_req_i, in_valid_i, in_last_i, core_ready_i, core_idle_i,
               res_empty_i, res_data_i, out_ready_i,
        input  job_gnt_o, job_core_o, in_ready_o, core_valid_o, core_start_o,
               res_rd_o, out_valid_o, out_data_o, job_done_o, busy_o, err_timeout_o
    );
endinterface

// File: rtl/ascon_job_scheduler.sv
// Dispatches whole ASCON jobs to the lowest idle core and drains results in issue order.
// Latency: grant combinational in idle; one output word per 3 cycles at best (read, capture, hold).
// Backpressure: in_ready follows the selected core; output word held until out_ready_i.
// Optional build macro ASCON_SCHED_WATCHDOG_EN adds a sticky stalled-result watchdog.
module ascon_job_scheduler #(
    parameter int NUM_CORES      = 2,
    parameter int RW             = 43,
    parameter int AUTH_BIT       = 42,
    parameter int DONE_BIT       = 40,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    ascon_job_scheduler_if.slave   bus
);
    localparam logic [1:0] I_IDLE   = 2'd0;
    localparam logic [1:0] I_STREAM = 2'd1;
    localparam logic [1:0] I_START  = 2'd2;

    localparam logic [1:0] O_IDLE   = 2'd0;
    localparam logic [1:0] O_FETCH  = 2'd1;
    localparam logic [1:0] O_HOLD   = 2'd2;

    localparam logic [1:0] LAST_IDX = 2'(NUM_CORES - 1);

    logic [1:0]           in_state;
    logic [1:0]           out_state;
    logic [1:0]           sel;
    logic [1:0]           gnt_sel;
    logic [1:0]           head;
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [2:0]           q_cnt;
    logic [1:0]           order_q [4];
    logic [NUM_CORES-1:0] busy;
    logic [NUM_CORES-1:0] busy_nxt;
    logic [NUM_CORES-1:0] avail;
    logic [NUM_CORES-1:0] core_valid;
    logic [NUM_CORES-1:0] core_start;
    logic [NUM_CORES-1:0] res_rd;
    logic [RW-1:0]        out_word;
    logic [RW-1:0]        head_data;
    logic                 grant;
    logic                 in_ready;
    logic                 beat_last;
    logic                 q_empty;
    logic                 head_empty;
    logic                 rd_fire;
    logic                 accept;
    logic                 end_of_job;

    // Order-queue pointers wrap at NUM_CORES, not at the storage size.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    assign head    = order_q[rd_ptr];
    assign q_empty = (q_cnt == 3'd0);

    // Pick the lowest-index core that is idle and not already holding a job.
    always_comb begin
        avail   = bus.core_idle_i & ~busy;
        gnt_sel = 2'd0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (avail[k]) gnt_sel = 2'(k);
        end
        // Gated by reset so nothing is granted while the array is being reset.
        grant = (in_state == I_IDLE) && bus.job_req_i && (|avail) && rst_n_i;
    end

    // Steer the host beat stream to the selected core and decode per-core strobes.
    always_comb begin
        in_ready   = 1'b0;
        core_valid = '0;
        core_start = '0;
        res_rd     = '0;
        head_empty = 1'b1;
        head_data  = '0;
        rd_fire    = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (sel == 2'(k)) begin
                if (in_state == I_STREAM) begin
                    in_ready      = bus.core_ready_i[k];
                    core_valid[k] = bus.in_valid_i;
                end
                core_start[k] = (in_state == I_START);
            end
            if (head == 2'(k)) begin
                head_empty = bus.res_empty_i[k];
                head_data  = bus.res_data_i[k*RW +: RW];
            end
        end
        rd_fire = (out_state == O_IDLE) && !q_empty && !head_empty;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (head == 2'(k)) res_rd[k] = rd_fire;
        end
        beat_last  = (in_state == I_STREAM) && bus.in_valid_i && in_ready && bus.in_last_i;
        accept     = (out_state == O_HOLD) && bus.out_ready_i;
        end_of_job = accept && (out_word[DONE_BIT] || out_word[AUTH_BIT]);
    end

    // Grant sets and job completion clears land on different cores, so both apply.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant && gnt_sel == 2'(k)) busy_nxt[k] = 1'b1;
            if (end_of_job && head == 2'(k)) busy_nxt[k] = 1'b0;
        end
    end

    // Input FSM: grant, stream beats to one core, then a single start pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_state <= I_IDLE;
            sel      <= 2'd0;
        end else begin
            case (in_state)
                I_IDLE: begin
                    if (grant) begin
                        sel      <= gnt_sel;
                        in_state <= I_STREAM;
                    end
                end
                I_STREAM: if (beat_last) in_state <= I_START;
                I_START:  in_state <= I_IDLE;
                default:  in_state <= I_IDLE;
            endcase
        end
    end

    // Issue-order queue and per-core busy flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            q_cnt  <= 3'd0;
            busy   <= '0;
            for (int i = 0; i < 4; i++) order_q[i] <= 2'd0;
        end else begin
            busy <= busy_nxt;
            if (grant) begin
                order_q[wr_ptr] <= gnt_sel;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (end_of_job) rd_ptr <= ptr_inc(rd_ptr);
            q_cnt <= q_cnt + {2'b00, grant} - {2'b00, end_of_job};
        end
    end

    // Output FSM: read the head core's FIFO, capture the word, hold it until accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_state <= O_IDLE;
            out_word  <= '0;
        end else begin
            case (out_state)
                O_IDLE:  if (rd_fire) out_state <= O_FETCH;
                O_FETCH: begin
                    out_word  <= head_data;
                    out_state <= O_HOLD;
                end
                O_HOLD:  if (accept) out_state <= O_IDLE;
                default: out_state <= O_IDLE;
            endcase
        end
    end

`ifdef ASCON_SCHED_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        wd_err;
    logic        wd_run;

    assign wd_run = !q_empty && (out_state == O_IDLE) && head_empty;

    // Count cycles the oldest job's FIFO stays empty; the error is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt <= 16'd0;
            wd_err <= 1'b0;
        end else begin
            if (q_empty || rd_fire) begin
                wd_cnt <= 16'd0;
            end else if (wd_run && wd_cnt != 16'hFFFF) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_run && ({16'd0, wd_cnt} >= 32'(TIMEOUT_CYCLES - 1))) wd_err <= 1'b1;
        end
    end

    assign bus.err_timeout_o = wd_err;
`else
    logic unused_timeout;
    assign unused_timeout    = ^TIMEOUT_CYCLES;
    assign bus.err_timeout_o = 1'b0;
`endif

    assign bus.job_gnt_o    = grant;
    assign bus.job_core_o   = grant ? gnt_sel : 2'd0;
    assign bus.in_ready_o   = in_ready;
    assign bus.core_valid_o = core_valid;
    assign bus.core_start_o = core_start;
    assign bus.res_rd_o     = res_rd;
    assign bus.out_valid_o  = (out_state == O_HOLD);
    assign bus.out_data_o   = out_word;
    assign bus.job_done_o   = end_of_job;
    assign bus.busy_o       = busy;
endmodule

// File: tb/tb_ascon_job_scheduler.sv
// Directed bench for the ASCON job scheduler with a behavioural result-FIFO model.
// Latency: checks start pulse, in-order drain, grant-after-done timing.
// Backpressure: exercises core_ready stalls and out_ready hold.
module tb_ascon_job_scheduler;
    localparam int NC = 2;
    localparam int RW = 43;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascon_job_scheduler_if #(.NUM_CORES(NC), .RW(RW)) bus ();

    ascon_job_scheduler #(
        .NUM_CORES(NC), .RW(RW), .AUTH_BIT(42), .DONE_BIT(40), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // word = {auth, tag_match, done, last, type, vld_byte, data}
    function automatic logic [RW-1:0] mkw(input logic auth, input logic done, input logic [31:0] d);
        return {auth, 1'b0, done, done, 3'b010, 4'hF, d};
    endfunction

    // ---------------- result FIFO model (non-show-ahead) ----------------
    logic [RW-1:0] fmem [NC][16];
    logic [3:0]    fwp [NC];
    logic [3:0]    frp [NC];
    logic [NC-1:0] push_vld = '0;
    logic [RW-1:0] push_dat = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) begin
                fwp[k] <= 4'd0;
                frp[k] <= 4'd0;
            end
            bus.res_data_i <= '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (push_vld[k]) begin
                    fmem[k][fwp[k]] <= push_dat;
                    fwp[k]          <= fwp[k] + 4'd1;
                end
                if (bus.res_rd_o[k]) begin
                    bus.res_data_i[k*RW +: RW] <= fmem[k][frp[k]];
                    frp[k]                     <= frp[k] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        bus.res_empty_i = '0;
        for (int k = 0; k < NC; k++) bus.res_empty_i[k] = (fwp[k] == frp[k]);
    end

    // ---------------- monitor ----------------
    int            cyc      = 0;
    int            done_cnt = 0;
    int            gnt_cnt  = 0;
    int            hbeats   = 0;
    int            beats [NC];
    int            rd_cnt [NC];
    int            done_cyc = -1;
    int            gnt_cyc  = -1;
    int            err_cyc  = -1;
    logic [1:0]    last_core = 2'd0;
    logic [RW-1:0] outq [$];

    initial begin
        for (int k = 0; k < NC; k++) begin
            beats[k]  = 0;
            rd_cnt[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.job_gnt_o) begin
                gnt_cnt   <= gnt_cnt + 1;
                gnt_cyc   <= cyc;
                last_core <= bus.job_core_o;
            end
            if (bus.job_done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (bus.in_valid_i && bus.in_ready_o) hbeats <= hbeats + 1;
            if (bus.out_valid_o && bus.out_ready_i) outq.push_back(bus.out_data_o);
            for (int k = 0; k < NC; k++) begin
                if (bus.core_valid_o[k] && bus.core_ready_i[k]) beats[k] <= beats[k] + 1;
                if (bus.res_rd_o[k]) rd_cnt[k] <= rd_cnt[k] + 1;
            end
            if (bus.err_timeout_o && err_cyc < 0) err_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int k, input logic [RW-1:0] w);
        push_dat = w;
        push_vld = NC'(1) << k;
        @(negedge clk);
        push_vld = '0;
    endtask

    task automatic grant_job(input logic [1:0] exp_core, input string tag);
        logic       seen = 1'b0;
        logic [1:0] core = 2'd0;
        @(negedge clk);
        bus.job_req_i = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (bus.job_gnt_o) begin
                seen = 1'b1;
                core = bus.job_core_o;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_gnt"}, 64'(seen), 64'd1);
        check({tag, "_core"}, 64'(core), 64'(exp_core));
        @(negedge clk);
        bus.job_req_i = 1'b0;
    endtask

    task automatic send_beats(input int n, input int core, input string tag);
        logic all_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic ok = 1'b0;
            bus.in_valid_i = 1'b1;
            bus.in_last_i  = (i == n - 1);
            for (int t = 0; t < 50; t++) begin
                #1;
                if (bus.in_ready_o) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) all_ok = 1'b0;
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        check({tag, "_beats_accepted"}, 64'(all_ok), 64'd1);
        #1;
        check({tag, "_start_pulse"}, 64'(bus.core_start_o), 64'(NC'(1) << core));
        @(negedge clk);
        #1;
        check({tag, "_start_end"}, 64'(bus.core_start_o), 64'd0);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int t = 0; t < 300; t++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(target));
    endtask

    // ---------------- main sequence ----------------
    int            d0, b0, hb0, rd0, g0;
    logic          bad;
    logic [RW-1:0] snap;
    logic [RW-1:0] expw [6];
    logic [RW-1:0] got;

    initial begin
        bus.job_req_i    = 1'b1;
        bus.in_valid_i   = 1'b1;
        bus.in_last_i    = 1'b0;
        bus.core_ready_i = '1;
        bus.core_idle_i  = '1;
        bus.out_ready_i  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 64'(bus.job_gnt_o), 64'd0);
        check("rst_core_valid", 64'(bus.core_valid_o), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_res_rd", 64'(bus.res_rd_o), 64'd0);
        check("rst_err", 64'(bus.err_timeout_o), 64'd0);
        bus.job_req_i  = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single job on core 0, four result words
        grant_job(2'd0, "t1");
        check("t1_busy", 64'(bus.busy_o), 64'h1);
        send_beats(6, 0, "t1");
        check("t1_core0_beats", 64'(beats[0]), 64'd6);
        for (int i = 0; i < 4; i++) expw[i] = mkw(1'b0, i == 3, 32'h100 + i);
        for (int i = 0; i < 4; i++) push(0, expw[i]);
        wait_done(1, "t1");
        repeat (5) @(negedge clk);
        check("t1_done_once", 64'(done_cnt), 64'd1);
        check("t1_words", 64'(outq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < outq.size()) ? outq[i] : 'x;
            check($sformatf("t1_word%0d", i), 64'(got), 64'(expw[i]));
        end
        check("t1_busy_clr", 64'(bus.busy_o), 64'h0);

        // 2: B results arrive first but must wait behind A
        outq.delete();
        d0 = done_cnt;
        grant_job(2'd0, "t2a");
        send_beats(2, 0, "t2a");
        grant_job(2'd1, "t2b");
        send_beats(2, 1, "t2b");
        check("t2_busy_both", 64'(bus.busy_o), 64'h3);
        rd0 = rd_cnt[1];
        for (int i = 0; i < 3; i++) expw[3+i] = mkw(1'b0, i == 2, 32'hB00 + i);
        for (int i = 0; i < 3; i++) expw[i]   = mkw(1'b0, i == 2, 32'hA00 + i);
        for (int i = 0; i < 3; i++) push(1, expw[3+i]);
        repeat (20) @(negedge clk);
        check("t2_no_rd1_early", 64'(rd_cnt[1] - rd0), 64'd0);
        check("t2_no_out_early", 64'(outq.size()), 64'd0);
        for (int i = 0; i < 3; i++) push(0, expw[i]);
        wait_done(d0 + 2, "t2");
        for (int i = 0; i < 6; i++) begin
            got = (i < outq.size()) ? outq[i] : 'x;
            check($sformatf("t2_order%0d", i), 64'(got), 64'(expw[i]));
        end

        // 3: saturation, then grant exactly one cycle after a job completes
        outq.delete();
        d0 = done_cnt;
        grant_job(2'd0, "t3a");
        send_beats(1, 0, "t3a");
        grant_job(2'd1, "t3b");
        send_beats(1, 1, "t3b");
        g0 = gnt_cnt;
        bus.job_req_i = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_no_gnt_saturated", 64'(gnt_cnt - g0), 64'd0);
        push(0, mkw(1'b0, 1'b1, 32'hA10));
        for (int t = 0; t < 50; t++) begin
            if (gnt_cnt != g0) break;
            @(negedge clk);
        end
        bus.job_req_i = 1'b0;
        check("t3_regrant", 64'(gnt_cnt - g0), 64'd1);
        check("t3_gnt_after_done", 64'(gnt_cyc - done_cyc), 64'd1);
        check("t3_gnt_core", 64'(last_core), 64'd0);
        send_beats(1, 0, "t3c");
        push(1, mkw(1'b0, 1'b1, 32'hB10));
        push(0, mkw(1'b0, 1'b1, 32'hC10));
        wait_done(d0 + 3, "t3");
        check("t3_busy_clr", 64'(bus.busy_o), 64'h0);

        // 4: input stall on core_ready and output hold on out_ready
        outq.delete();
        d0 = done_cnt;
        grant_job(2'd0, "t4");
        b0  = beats[0];
        hb0 = hbeats;
        bus.in_valid_i = 1'b1;
        bus.in_last_i  = 1'b0;
        @(negedge clk);
        bus.core_ready_i = 2'b10;
        bad = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            if (bus.in_ready_o) bad = 1'b1;
            @(negedge clk);
        end
        check("t4_in_stalled", 64'(bad), 64'd0);
        check("t4_no_beat_while_stalled", 64'(hbeats - hb0), 64'd1);
        bus.core_ready_i = 2'b11;
        send_beats(2, 0, "t4");
        check("t4_core_beats", 64'(beats[0] - b0), 64'd3);
        check("t4_host_beats", 64'(hbeats - hb0), 64'd3);
        bus.out_ready_i = 1'b0;
        expw[0] = mkw(1'b0, 1'b0, 32'hD00);
        expw[1] = mkw(1'b0, 1'b1, 32'hD01);
        push(0, expw[0]);
        push(0, expw[1]);
        for (int t = 0; t < 50; t++) begin
            #1;
            if (bus.out_valid_o) break;
            @(negedge clk);
        end
        snap = bus.out_data_o;
        rd0  = rd_cnt[0];
        bad  = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            if (!bus.out_valid_o || bus.out_data_o !== snap) bad = 1'b1;
        end
        check("t4_hold_word", 64'(snap), 64'(expw[0]));
        check("t4_hold_stable", 64'(bad), 64'd0);
        check("t4_no_rd_in_hold", 64'(rd_cnt[0] - rd0), 64'd0);
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        wait_done(d0 + 1, "t4");
        got = (outq.size() > 1) ? outq[1] : 'x;
        check("t4_second_word", 64'(got), 64'(expw[1]));

        // 5: auth-fail word ends the job
        outq.delete();
        d0 = done_cnt;
        grant_job(2'd0, "t5");
        send_beats(1, 0, "t5");
        push(0, mkw(1'b1, 1'b0, 32'hE00));
        wait_done(d0 + 1, "t5");
        check("t5_busy_clr", 64'(bus.busy_o), 64'h0);
        check("t5_words", 64'(outq.size()), 64'd1);

        // 6a: watchdog on a job whose FIFO stays empty
        grant_job(2'd0, "t6");
        g0 = gnt_cyc;
        send_beats(1, 0, "t6");
        repeat (40) @(negedge clk);
`ifdef ASCON_SCHED_WATCHDOG_EN
        check("t6_wd_delay", 64'((err_cyc - g0 >= 16) && (err_cyc - g0 <= 18)), 64'd1);
        check("t6_wd_sticky", 64'(bus.err_timeout_o), 64'd1);
`else
        check("t6_wd_off", 64'(bus.err_timeout_o), 64'd0);
`endif

        // 6b: reset mid-stream
        grant_job(2'd1, "t6r");
        bus.in_valid_i = 1'b1;
        bus.in_last_i  = 1'b0;
        bus.job_req_i  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_core_valid", 64'(bus.core_valid_o), 64'd0);
        check("t6_rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("t6_rst_gnt", 64'(bus.job_gnt_o), 64'd0);
        check("t6_rst_busy", 64'(bus.busy_o), 64'd0);
        check("t6_rst_err", 64'(bus.err_timeout_o), 64'd0);
        check("t6_rst_out_data", 64'(bus.out_data_o), 64'd0);
        bus.in_valid_i = 1'b0;
        bus.job_req_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        outq.delete();
        d0 = done_cnt;
        grant_job(2'd0, "t6p");
        send_beats(1, 0, "t6p");
        push(0, mkw(1'b0, 1'b1, 32'hF00));
        wait_done(d0 + 1, "t6p");
        got = (outq.size() > 0) ? outq[0] : 'x;
        check("t6_post_reset_word", 64'(got), 64'(mkw(1'b0, 1'b1, 32'hF00)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "global timeout");
    end
endmodule
